// File: rtl/step_pkg.sv
// Shared step-interface definitions for step_decoder and step_controller.
// Holds timing defaults, the direction encoding and the edge-tracker state type.
package step_pkg;

   localparam int unsigned DEF_MIN_PULSE = 1000;
   localparam int unsigned DEF_MIN_GAP   = 1000;
   localparam int unsigned DEF_WINDOW    = 500_000;

   localparam logic DIR_POS = 1'b1;

   typedef enum logic {
      ST_LOW  = 1'b0,
      ST_HIGH = 1'b1
   } step_state_t;

   function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
      if (v > 17'sd32767) return 16'sh7FFF;
      else if (v < -17'sd32768) return 16'sh8000;
      else return $signed(v[15:0]);
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/step_decoder.sv
// Step/dir pin decoder: qualifies pulse and gap widths, tracks position and
// reports net step count per fixed measurement window.
//
//   state   | meaning
//   --------+----------------------------------------------
//   ST_LOW  | synchronized step low, counting gap cycles
//   ST_HIGH | synchronized step high, counting pulse cycles
module step_decoder
   import step_pkg::*;
#(
   parameter int unsigned MIN_PULSE = DEF_MIN_PULSE,
   parameter int unsigned MIN_GAP   = DEF_MIN_GAP,
   parameter int unsigned WINDOW    = DEF_WINDOW
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               step,
   input  logic               dir,
   input  logic               clear,
   output logic signed [31:0] position,
   output logic signed [15:0] window_steps,
   output logic               window_valid,
   output logic               step_strobe,
   output logic               pulse_error,
   output logic               dir_error
);

   logic step_s, dir_s;

   sync2 u_sync_step (.clock(clock), .reset(reset), .d(step), .q(step_s));
   sync2 u_sync_dir  (.clock(clock), .reset(reset), .d(dir),  .q(dir_s));

   step_state_t        state, state_nx;
   logic [31:0]        cnt;
   logic               dir_cap;
   logic               gap_exempt;
   logic               rise, fall, accept, short_pulse, short_gap;
   logic signed [31:0] step_inc;
   logic signed [15:0] acc;
   logic signed [16:0] acc_sum;
   logic [31:0]        win_cnt;
   logic               win_last;

   always_ff @(posedge clock) begin
      if (reset) state <= ST_LOW;
      else       state <= state_nx;
   end

   // The FSM state doubles as the delayed copy of step_s for edge detection.
   always_comb begin
      state_nx = state;
      rise     = 1'b0;
      fall     = 1'b0;
      case (state)
         ST_LOW:  if (step_s)  begin state_nx = ST_HIGH; rise = 1'b1; end
         ST_HIGH: if (!step_s) begin state_nx = ST_LOW;  fall = 1'b1; end
      endcase
      accept      = fall && (cnt >= MIN_PULSE);
      short_pulse = fall && !accept;
      short_gap   = rise && !gap_exempt && (cnt < MIN_GAP);
      step_inc    = '0;
      if (accept) step_inc = (dir_cap == DIR_POS) ? 32'sd1 : -32'sd1;
      acc_sum     = $signed({acc[15], acc}) + $signed(step_inc[16:0]);
      win_last    = (win_cnt == WINDOW - 1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt          <= '0;
         dir_cap      <= 1'b0;
         gap_exempt   <= 1'b1;
         step_strobe  <= 1'b0;
         position     <= '0;
         pulse_error  <= 1'b0;
         dir_error    <= 1'b0;
      end else begin
         if (rise || fall)   cnt <= 32'd1;
         else if (cnt != '1) cnt <= cnt + 32'd1;
         if (rise) dir_cap <= dir_s;
         step_strobe <= accept;
         if (clear) begin
            position    <= '0;
            pulse_error <= 1'b0;
            dir_error   <= 1'b0;
            gap_exempt  <= 1'b1;
         end else begin
            position <= position + step_inc;
            if (short_pulse || short_gap) pulse_error <= 1'b1;
            if (state == ST_HIGH && dir_s != dir_cap) dir_error <= 1'b1;
            if (rise) gap_exempt <= 1'b0;
         end
      end
   end

   // Window accumulator is independent of clear so rate reporting never drops steps.
   always_ff @(posedge clock) begin
      if (reset) begin
         win_cnt      <= '0;
         acc          <= '0;
         window_steps <= '0;
         window_valid <= 1'b0;
      end else begin
         window_valid <= win_last;
         if (win_last) begin
            win_cnt      <= '0;
            window_steps <= sat16(acc_sum);
            acc          <= '0;
         end else begin
            win_cnt <= win_cnt + 32'd1;
            acc     <= sat16(acc_sum);
         end
      end
   end

endmodule
